// File: rtl/core_pkg.sv
// Shared core definitions: address width, reset/trap vectors and the
// fetch-sequencer state and redirect-cause encodings.
package core_pkg;

    localparam int unsigned      CORE_XLEN        = 32;
    localparam logic [31:0]      RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0]      TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } pcseq_state_t;

    // Encoded in ascending priority so a plain magnitude compare decides
    // whether a new redirect may overwrite a pending one.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        MRET   = 2'd2,
        TRAP   = 2'd3
    } redir_cause_t;

    function automatic logic cause_outranks(input redir_cause_t a, input redir_cause_t b);
        return a > b;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_mux.sv
// Combinational next-PC priority select (trap > mret > branch > stall > +4).
// Honours PC_MISALIGN_TRAP_EN: misaligned branch/mret targets become traps.
module next_pc_mux
    import core_pkg::*;
#(
    parameter int unsigned     XLEN        = CORE_XLEN,
    parameter logic [XLEN-1:0] TRAP_VECTOR = TRAP_VECTOR_DEF
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic [XLEN-1:0] next_pc_o,
    output redir_cause_t    cause_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] br_tgt_w;
    logic [XLEN-1:0] mepc_tgt_w;
    logic            br_lowbits_w;
    logic            mepc_lowbits_w;

    assign br_tgt_w       = br_target_i & ALIGN_MASK;
    assign mepc_tgt_w     = mepc_i & ALIGN_MASK;
    assign br_lowbits_w   = |br_target_i[1:0];
    assign mepc_lowbits_w = |mepc_i[1:0];

    always_comb begin
        cause_o    = NONE;
        next_pc_o  = pc_i + XLEN'(4);
        misalign_o = 1'b0;
        if (trap_i) begin
            cause_o   = TRAP;
            next_pc_o = TRAP_VECTOR;
        end else if (mret_i) begin
            cause_o   = MRET;
            next_pc_o = mepc_tgt_w;
`ifdef PC_MISALIGN_TRAP_EN
            if (mepc_lowbits_w) begin
                cause_o    = TRAP;
                next_pc_o  = TRAP_VECTOR;
                misalign_o = 1'b1;
            end
`endif
        end else if (br_taken_i) begin
            cause_o   = BRANCH;
            next_pc_o = br_tgt_w;
`ifdef PC_MISALIGN_TRAP_EN
            if (br_lowbits_w) begin
                cause_o    = TRAP;
                next_pc_o  = TRAP_VECTOR;
                misalign_o = 1'b1;
            end
`endif
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end
`ifndef PC_MISALIGN_TRAP_EN
        // Low target bits are simply cleared; keep the detectors referenced.
        misalign_o = misalign_o & br_lowbits_w & mepc_lowbits_w;
`endif
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: owns the IF program counter, the imem handshake and
// the redirect flushes. Optional macro PC_MISALIGN_TRAP_EN enables misalign traps.
module pc_sequencer
    import core_pkg::*;
#(
    parameter int unsigned     XLEN         = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            flush_if_id_o,
    output logic            flush_id_ex_o,
    output logic            misalign_o
);

    pcseq_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            req_q;
    logic            pend_vld_q;
    logic [XLEN-1:0] pend_tgt_q;
    redir_cause_t    pend_cause_q;

    logic [XLEN-1:0] next_pc_w;
    redir_cause_t    cause_w;
    logic            misalign_w;
    logic            active_w;
    logic            redir_w;
    logic            accept_w;

    next_pc_mux #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_pc_mux (
        .pc_i        (pc_q),
        .stall_i     (stall_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .trap_i      (trap_i),
        .mret_i      (mret_i),
        .mepc_i      (mepc_i),
        .next_pc_o   (next_pc_w),
        .cause_o     (cause_w),
        .misalign_o  (misalign_w)
    );

    assign active_w = (state_q != BOOT);
    assign redir_w  = (cause_w != NONE);

    // A redirect is taken (and flushes) only if nothing of equal or higher
    // priority is already parked waiting for the memory.
    assign accept_w = active_w && redir_w &&
                      (!pend_vld_q || cause_outranks(cause_w, pend_cause_q));

    always_comb begin
        pc_d = next_pc_w;
        if (pend_vld_q && !accept_w) begin
            pc_d = pend_tgt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            req_q        <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_tgt_q   <= '0;
            pend_cause_q <= NONE;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH, WAIT: begin
                    if (imem_ready_i) begin
                        state_q      <= FETCH;
                        pc_q         <= pc_d;
                        pend_vld_q   <= 1'b0;
                        pend_cause_q <= NONE;
                    end else begin
                        // Address must stay put until the memory accepts it.
                        state_q <= WAIT;
                        if (accept_w) begin
                            pend_vld_q   <= 1'b1;
                            pend_tgt_q   <= next_pc_w;
                            pend_cause_q <= cause_w;
                        end
                    end
                end
                default: begin
                    state_q <= BOOT;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign imem_addr_o   = pc_q;
    assign imem_req_o    = req_q;
    assign pc_valid_o    = active_w && imem_ready_i && !stall_i && !redir_w && !pend_vld_q;
    assign flush_if_id_o = accept_w;
    assign flush_id_ex_o = accept_w;
    assign misalign_o    = accept_w & misalign_w;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        trap_i = 1'b0;
    logic        mret_i = 1'b0;
    logic [31:0] mepc_i = '0;
    logic        imem_ready_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        misalign_o;

    int n_cmp = 0;
    int n_err = 0;
    int flush_cnt = 0;
    int valid_cnt = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .trap_i        (trap_i),
        .mret_i        (mret_i),
        .mepc_i        (mepc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .misalign_o    (misalign_o)
    );

    // Reference model: PC, "just out of reset" flag and a ranked pending redirect.
    bit          m_boot = 1'b1;
    int          m_pend_rank = 0;
    logic [31:0] m_pend_tgt = '0;
    logic [31:0] m_pc = RV;

    always @(negedge clk) begin
        int          r;
        logic [31:0] tgt;
        bit          mis;
        bit          acc;
        logic        e_req, e_val, e_fl, e_mis;
        bit          bad;

        r = 0; tgt = '0; mis = 1'b0;
        if (trap_i) begin
            r = 3; tgt = TV;
        end else if (mret_i) begin
            r = 2; tgt = mepc_i - 32'(mepc_i % 4);
        end else if (br_taken_i) begin
            r = 1; tgt = br_target_i - 32'(br_target_i % 4);
        end
`ifdef PC_MISALIGN_TRAP_EN
        if ((r == 2 && (mepc_i % 4) != 0) || (r == 1 && (br_target_i % 4) != 0)) begin
            r = 3; tgt = TV; mis = 1'b1;
        end
`endif
        acc = 1'b0;
        if (rst) begin
            m_boot = 1'b1; m_pend_rank = 0; m_pc = RV;
            e_req = 1'b0; e_val = 1'b0; e_fl = 1'b0; e_mis = 1'b0;
        end else if (m_boot) begin
            e_req = 1'b0; e_val = 1'b0; e_fl = 1'b0; e_mis = 1'b0;
        end else begin
            acc   = (r > m_pend_rank);
            e_req = 1'b1;
            e_val = imem_ready_i && !stall_i && r == 0 && m_pend_rank == 0;
            e_fl  = acc;
            e_mis = acc && mis;
        end

        bad = (pc_o !== m_pc) || (imem_addr_o !== m_pc) || (imem_req_o !== e_req) ||
              (pc_valid_o !== e_val) || (flush_if_id_o !== e_fl) ||
              (flush_id_ex_o !== e_fl) || (misalign_o !== e_mis);
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL cycle_check t=%0t got pc=%h addr=%h req=%b val=%b fif=%b fex=%b mis=%b / want pc=%h req=%b val=%b fl=%b mis=%b",
                     $time, pc_o, imem_addr_o, imem_req_o, pc_valid_o, flush_if_id_o,
                     flush_id_ex_o, misalign_o, m_pc, e_req, e_val, e_fl, e_mis);
        end
        if (flush_if_id_o) flush_cnt++;
        if (pc_valid_o) valid_cnt++;

        if (!rst) begin
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (imem_ready_i) begin
                if (acc) m_pc = tgt;
                else if (m_pend_rank != 0) m_pc = m_pend_tgt;
                else if (!stall_i) m_pc = m_pc + 32'd4;
                m_pend_rank = 0;
            end else if (acc) begin
                m_pend_rank = r;
                m_pend_tgt  = tgt;
            end
        end
    end

    task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_cnt(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic stl, input logic br, input logic [31:0] bt,
                        input logic trp, input logic mr, input logic [31:0] mp);
        imem_ready_i = rdy; stall_i = stl; br_taken_i = br; br_target_i = bt;
        trap_i = trp; mret_i = mr; mepc_i = mp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_val("reset_pc", pc_o, RV);
        expect_val("reset_req", {31'b0, imem_req_o}, 32'h0);
        rst = 1'b0;

        idle();                                  // BOOT cycle
        expect_val("boot_pc", pc_o, 32'h0);
        flush_cnt = 0; valid_cnt = 0;
        idle(); expect_val("seq_4", pc_o, 32'h4);
        idle(); expect_val("seq_8", pc_o, 32'h8);
        expect_cnt("seq_valid_cnt", valid_cnt, 2);
        expect_cnt("seq_no_flush", flush_cnt, 0);

        // Memory not ready for three cycles, trap arrives in the second
        flush_cnt = 0; valid_cnt = 0;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); expect_val("wait_addr1", imem_addr_o, 32'h8);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); expect_val("wait_addr2", imem_addr_o, 32'h8);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); expect_val("wait_addr3", imem_addr_o, 32'h8);
        idle(); expect_val("wait_trap_pc", pc_o, TV);
        expect_cnt("wait_flush_once", flush_cnt, 1);
        expect_cnt("wait_stale_invalid", valid_cnt, 0);

        // Branch redirect 0x10 -> 0x40
        step(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0); expect_val("br_to_10", pc_o, 32'h10);
        flush_cnt = 0;
        step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0); expect_val("br_to_40", pc_o, 32'h40);
        idle(); expect_val("br_then_44", pc_o, 32'h44);
        expect_cnt("br_flush_one_cycle", flush_cnt, 1);

        // Stall at 0x20, then a branch overrides the stall
        step(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
        valid_cnt = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); expect_val("stall_hold1", pc_o, 32'h20);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); expect_val("stall_hold2", pc_o, 32'h20);
        expect_cnt("stall_no_valid", valid_cnt, 0);
        step(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0); expect_val("stall_br_80", pc_o, 32'h80);

        // Priority: trap over branch, mret over branch
        step(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0); expect_val("trap_over_br", pc_o, TV);
        step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h300); expect_val("mret_over_br", pc_o, 32'h300);

        // Sequential wrap at the top of the address space
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0); expect_val("br_top", pc_o, 32'hFFFF_FFFC);
        idle(); expect_val("wrap_0", pc_o, 32'h0);

        // Misaligned targets
        step(1'b1, 1'b0, 1'b1, 32'h42, 1'b0, 1'b0, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
        expect_val("misalign_br", pc_o, TV);
`else
        expect_val("misalign_br", pc_o, 32'h40);
`endif
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h203);
`ifdef PC_MISALIGN_TRAP_EN
        expect_val("misalign_mret", pc_o, TV);
`else
        expect_val("misalign_mret", pc_o, 32'h200);
`endif
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);

        // Pending redirects while the memory stalls: only higher priority overwrites
        flush_cnt = 0;
        step(1'b0, 1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h70);
        step(1'b0, 1'b0, 1'b1, 32'h90, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_val("pend_addr_held", imem_addr_o, 32'h200);
        idle(); expect_val("pend_trap_wins", pc_o, TV);
        expect_cnt("pend_flush_cnt", flush_cnt, 3);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h74);
        step(1'b0, 1'b0, 1'b1, 32'h90, 1'b0, 1'b0, 32'h0);
        idle(); expect_val("pend_mret_kept", pc_o, 32'h74);

        // Reset asserted mid-WAIT discards the pending target
        step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
        br_taken_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        expect_val("midwait_rst_pc", pc_o, RV);
        expect_val("midwait_rst_req", {31'b0, imem_req_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(); expect_val("rst_boot_pc", pc_o, RV);
        idle(); expect_val("rst_seq_4", pc_o, 32'h4);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
